core_control_redirect_arbiter: RTL
==================================

// Module: core_control_redirect_arbiter
// PURPOSE
//  Arbitrates the three PC-redirect sources into the single fetch redirect port:
//  exception vector, writeback PC write and issue-stage branch.
//  Holds the winning redirect until fetch accepts it, then runs a fixed flush window.
//  During the window, wrong-path branch requests are discarded.
//  Sits in core/control, between the branch/writeback/exception controls and fetch.
// PARAMETERS
//  PTR_W         30  word-address width of every target (byte address >> 2)
//  FLUSH_CYCLES  2   cycles flush stays high after redirect accept; 0 = no window
// PORTS
//  clk             in   1      core clock
//  rst_n           in   1      asynchronous reset, active low
//  exc_valid       in   1      exception redirect request (highest priority)
//  exc_target      in   PTR_W  exception vector
//  wb_valid        in   1      writeback PC-write request (middle priority)
//  wb_target       in   PTR_W  written PC
//  br_valid        in   1      issue-stage branch request (lowest priority)
//  br_target       in   PTR_W  branch target
//  redirect_ready  in   1      fetch accepts redirect this cycle
//  redirect_valid  out  1      redirect offered to fetch
//  redirect_target out  PTR_W  redirect address
//  flush           out  1      kill fetch/decode contents this cycle
//  stall_issue     out  1      block issue while redirect pending or flushing
//  dropped         out  1      one-cycle pulse: a request was discarded
// BEHAVIOUR
//  States: IDLE, PEND, FLUSH. All outputs are registered or decoded from state.
//  Reset (async, rst_n=0):
//   - state=IDLE, redirect_valid=0, redirect_target=0.
//   - flush=0, dropped=0, stall_issue=0, flush counter=0.
//  Priority: exc > wb > br. Pending priority is stored with pend_target.
//  IDLE:
//   - Any request: latch the highest-priority target, go to PEND.
//   - Lower-priority simultaneous requests are dropped; dropped=1 next cycle.
//   - Request-to-redirect_valid latency is exactly 1 cycle.
//  PEND:
//   - redirect_valid=1, redirect_target=pend_target, stall_issue=1.
//   - A request of strictly higher priority than pending replaces pend_target; stay in PEND.
//     This holds even if redirect_ready=1 in the same cycle: the accepted one is consumed.
//   - Equal or lower priority request: dropped.
//   - redirect_ready=1 with no replacement: go to FLUSH with counter=FLUSH_CYCLES.
//     If FLUSH_CYCLES=0, go to IDLE instead.
//   - redirect_valid and redirect_target stay stable until accepted or replaced.
//  FLUSH:
//   - flush=1, stall_issue=1; counter decrements each cycle; at counter==1, next state is IDLE.
//   - br_valid is dropped.
//   - exc_valid or wb_valid latches (priority rule applies) and goes to PEND, aborting the window.
//  dropped is the OR of all discards in the previous cycle; it is not a count.
//  Counter width is $clog2(FLUSH_CYCLES+1).
//  Targets pass through unmodified (no arithmetic).
//  rst_n low in any state aborts immediately: redirect_valid falls asynchronously.
// TESTING
//  1. IDLE, br_valid=1, br_target=0x100, ready=1:
//     -> valid=1, target=0x100 at cycle+1; flush=1 for cycles +2,+3; IDLE at +4.
//  2. br 0x100 and wb 0x200 in the same cycle:
//     -> target=0x200, dropped=1 one cycle later, exactly one redirect issued.
//  3. PEND br 0x100 with ready=0, exc 0x008 arrives:
//     -> target becomes 0x008 next cycle; a later br 0x300 is dropped.
//  4. In FLUSH cycle 1: br 0x40 is dropped; wb 0x80 -> PEND, target=0x80, flush=0 next cycle.
//  5. FLUSH_CYCLES=0: br accepted with ready=1 -> IDLE next cycle, flush never asserted.
//  6. rst_n pulsed low mid-PEND -> valid/stall/flush=0 immediately; a new br after release
//     -> normal 1-cycle redirect.

Source files
------------

// File: rtl/core_control_redirect_arbiter_if.sv
// Redirect-arbiter bus: three prioritised redirect requests in, one fetch
// redirect port out, plus the flush/stall/dropped side-band.
interface core_control_redirect_arbiter_if #(
    parameter int PTR_W = 30
);
    logic             exc_valid;
    logic [PTR_W-1:0] exc_target;
    logic             wb_valid;
    logic [PTR_W-1:0] wb_target;
    logic             br_valid;
    logic [PTR_W-1:0] br_target;
    logic             redirect_ready;
    logic             redirect_valid;
    logic [PTR_W-1:0] redirect_target;
    logic             flush;
    logic             stall_issue;
    logic             dropped;

    // Arbiter side
    modport slave (
        input  exc_valid, exc_target, wb_valid, wb_target, br_valid, br_target,
        input  redirect_ready,
        output redirect_valid, redirect_target, flush, stall_issue, dropped
    );

    // Requester / fetch side
    modport master (
        output exc_valid, exc_target, wb_valid, wb_target, br_valid, br_target,
        output redirect_ready,
        input  redirect_valid, redirect_target, flush, stall_issue, dropped
    );
endinterface

// File: rtl/core_control_redirect_arbiter.sv
// PC-redirect arbiter: picks exc > wb > br, holds the winner on the fetch
// redirect port until accepted, then runs a fixed flush window in which
// wrong-path branch requests are discarded.
//
//   state | meaning
//   IDLE  | no redirect outstanding
//   PEND  | redirect offered to fetch, waiting for redirect_ready
//   FLUSH | redirect accepted, fetch/decode being flushed for FLUSH_CYCLES
module core_control_redirect_arbiter #(
    parameter int PTR_W        = 30,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    core_control_redirect_arbiter_if.slave        io_rdr
);
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    // Priority codes: larger wins; 0 means no request.
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BR   = 2'd1;
    localparam logic [1:0] PRIO_WB   = 2'd2;
    localparam logic [1:0] PRIO_EXC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             r_state,  w_nxt_state;
    logic [PTR_W-1:0]   r_target, w_nxt_target;
    logic [1:0]         r_prio,   w_nxt_prio;
    logic [CNT_W-1:0]   r_cnt,    w_nxt_cnt;
    logic               r_dropped, w_nxt_dropped;

    logic               w_any;
    logic               w_multi;
    logic [1:0]         w_win_prio;
    logic [PTR_W-1:0]   w_win_target;

    // Fixed-priority pick among the incoming requests.
    always_comb begin
        w_win_prio   = PRIO_NONE;
        w_win_target = '0;
        if (io_rdr.exc_valid) begin
            w_win_prio   = PRIO_EXC;
            w_win_target = io_rdr.exc_target;
        end else if (io_rdr.wb_valid) begin
            w_win_prio   = PRIO_WB;
            w_win_target = io_rdr.wb_target;
        end else if (io_rdr.br_valid) begin
            w_win_prio   = PRIO_BR;
            w_win_target = io_rdr.br_target;
        end
    end

    assign w_any   = io_rdr.exc_valid | io_rdr.wb_valid | io_rdr.br_valid;
    assign w_multi = (io_rdr.exc_valid & io_rdr.wb_valid) |
                     (io_rdr.exc_valid & io_rdr.br_valid) |
                     (io_rdr.wb_valid  & io_rdr.br_valid);

    // Next-state, pending-redirect and discard decode.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_target  = r_target;
        w_nxt_prio    = r_prio;
        w_nxt_cnt     = r_cnt;
        w_nxt_dropped = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nxt_state   = PEND;
                    w_nxt_target  = w_win_target;
                    w_nxt_prio    = w_win_prio;
                    w_nxt_dropped = w_multi;
                end
            end
            PEND: begin
                if (w_any && (w_win_prio > r_prio)) begin
                    // Superseding request; an offer accepted this same cycle is
                    // simply consumed and the new target is offered next.
                    w_nxt_target  = w_win_target;
                    w_nxt_prio    = w_win_prio;
                    w_nxt_dropped = w_multi;
                end else begin
                    w_nxt_dropped = w_any;
                    if (io_rdr.redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            w_nxt_state = IDLE;
                        end else begin
                            w_nxt_state = FLUSH;
                            w_nxt_cnt   = CNT_W'(FLUSH_CYCLES);
                        end
                    end
                end
            end
            FLUSH: begin
                if (io_rdr.exc_valid || io_rdr.wb_valid) begin
                    // Non-speculative redirect aborts the window.
                    w_nxt_state   = PEND;
                    w_nxt_target  = w_win_target;
                    w_nxt_prio    = w_win_prio;
                    w_nxt_dropped = w_multi;
                end else begin
                    w_nxt_dropped = io_rdr.br_valid;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_target  <= '0;
            r_prio    <= PRIO_NONE;
            r_cnt     <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_target  <= w_nxt_target;
            r_prio    <= w_nxt_prio;
            r_cnt     <= w_nxt_cnt;
            r_dropped <= w_nxt_dropped;
        end
    end

    assign io_rdr.redirect_valid  = (r_state == PEND);
    assign io_rdr.redirect_target = r_target;
    assign io_rdr.flush           = (r_state == FLUSH);
    assign io_rdr.stall_issue     = (r_state == PEND) || (r_state == FLUSH);
    assign io_rdr.dropped         = r_dropped;
endmodule
